// File: rtl/oap_link_pkg.sv
// Shared types and constants for the opc7 host-side serial link endpoint.
// Frame on the wire: start bit 0, WORD_W data bits LSB first, stop bit 1.
package oap_link_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    localparam logic LINK_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Per-bit cycle counters must reach BIT_CYCLES + BIT_CYCLES/2 - 1 (max 23).
    localparam int CYC_W = 5;

    function automatic int bit_cnt_w(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/oap_link_rx.sv
// Serial receiver: input register, frame FSM, mid-bit sampler and a one-word
// holding register with valid/ready handshake, framing-error and overrun pulses.
module oap_link_rx
    import oap_link_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              link_in,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_overrun
);

    localparam int BW = bit_cnt_w(WORD_W);
    localparam logic [BW-1:0]    LAST_BIT   = BW'(WORD_W - 1);
    // From the start-bit detection cycle, the first data sample lands mid-way into bit 0.
    localparam logic [CYC_W-1:0] FIRST_WAIT = CYC_W'(BIT_CYCLES + BIT_CYCLES / 2 - 1);
    localparam logic [CYC_W-1:0] BIT_WAIT   = CYC_W'(BIT_CYCLES - 1);

    rx_state_t         state_q, state_d;
    logic              s_in_q;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= RX_IDLE;
            s_in_q  <= LINK_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_in_q  <= link_in;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (s_in_q == START_BIT) begin
                    state_d = RX_DATA;
                    cnt_d   = FIRST_WAIT;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_WAIT;
                    shift_d = {s_in_q, shift_q[WORD_W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (s_in_q == LINK_IDLE) begin
                        state_d = RX_IDLE;
                        // A same-cycle handshake frees the holding register for the new word.
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                if (s_in_q == LINK_IDLE) begin
                    state_d = RX_IDLE;
                end
            end
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: rtl/oap_link_host.sv
// Host endpoint for one opc7 array boundary link: serialiser driving a node rx
// pin and an independent deserialiser (oap_link_rx) listening to a node tx pin.
module oap_link_host
    import oap_link_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              link_out,
    input  logic              link_in,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_overrun
);

    localparam int BW = bit_cnt_w(WORD_W);
    localparam logic [BW-1:0]    LAST_BIT = BW'(WORD_W - 1);
    localparam logic [CYC_W-1:0] BC_LAST  = CYC_W'(BIT_CYCLES - 1);

    tx_state_t         state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              link_q, link_d;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            link_q  <= LINK_IDLE;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            link_q  <= link_d;
        end
    end

    // link_d is the line level for the state being entered, so link_out stays glitch-free.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        link_d   = link_q;
        tx_ready = (state_q == TX_IDLE);
        case (state_q)
            TX_IDLE: begin
                link_d = LINK_IDLE;
                if (tx_valid) begin
                    shift_d = tx_data;
                    state_d = TX_START;
                    cyc_d   = '0;
                    link_d  = START_BIT;
                end
            end
            TX_START: begin
                if (cyc_q == BC_LAST) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                    link_d  = shift_q[0];
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (cyc_q == BC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = TX_STOP;
                        link_d  = LINK_IDLE;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        link_d  = shift_q[1];
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cyc_q == BC_LAST) begin
                    cyc_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
        endcase
    end

    assign link_out = link_q;

    oap_link_rx #(
        .WORD_W    (WORD_W),
        .BIT_CYCLES(BIT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .resetb      (resetb),
        .link_in     (link_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

endmodule

// File: tb/tb_oap_link_host.sv
// Directed bench for oap_link_host: three instances (32b/1clk, 32b/4clk, 8b/3clk).
module tb_oap_link_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: WORD_W=32, BIT_CYCLES=1, optional loopback.
    logic [31:0] a_tx_data, a_rx_data;
    logic a_tx_valid, a_tx_ready, a_link_out, a_link_in, a_rx_valid, a_rx_ready;
    logic a_ferr, a_ovr, a_loop, a_drv;
    assign a_link_in = a_loop ? a_link_out : a_drv;

    oap_link_host #(.WORD_W(32), .BIT_CYCLES(1)) u_a (
        .clk(clk), .resetb(resetb), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .link_out(a_link_out), .link_in(a_link_in),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
        .rx_frame_err(a_ferr), .rx_overrun(a_ovr));

    // Instance B: WORD_W=32, BIT_CYCLES=4, hard loopback, always ready.
    logic [31:0] b_tx_data, b_rx_data;
    logic b_tx_valid, b_tx_ready, b_link, b_rx_valid, b_ferr, b_ovr;
    logic b_rx_ready = 1'b1;

    oap_link_host #(.WORD_W(32), .BIT_CYCLES(4)) u_b (
        .clk(clk), .resetb(resetb), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .link_out(b_link), .link_in(b_link),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
        .rx_frame_err(b_ferr), .rx_overrun(b_ovr));

    // Instance C: WORD_W=8, BIT_CYCLES=3, independent TX and RX streams.
    logic [7:0] c_tx_data, c_rx_data;
    logic c_tx_valid, c_tx_ready, c_link_out, c_drv, c_rx_valid, c_rx_ready, c_ferr, c_ovr;

    oap_link_host #(.WORD_W(8), .BIT_CYCLES(3)) u_c (
        .clk(clk), .resetb(resetb), .tx_data(c_tx_data), .tx_valid(c_tx_valid),
        .tx_ready(c_tx_ready), .link_out(c_link_out), .link_in(c_drv),
        .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
        .rx_frame_err(c_ferr), .rx_overrun(c_ovr));

    // Pulse counters and B's transaction log, sampled mid-cycle.
    int a_ferr_cnt = 0, a_ovr_cnt = 0, b_err_cnt = 0, c_err_cnt = 0;
    int b_acc_q[$];
    logic [31:0] b_rx_q[$];
    always @(negedge clk) begin
        if (a_ferr) a_ferr_cnt <= a_ferr_cnt + 1;
        if (a_ovr)  a_ovr_cnt  <= a_ovr_cnt + 1;
        if (b_ferr || b_ovr) b_err_cnt <= b_err_cnt + 1;
        if (c_ferr || c_ovr) c_err_cnt <= c_err_cnt + 1;
        if (b_tx_valid && b_tx_ready) b_acc_q.push_back(cyc);
        if (b_rx_valid && b_rx_ready) b_rx_q.push_back(b_rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer a word on A and return one cycle after acceptance (start bit on the line).
    task automatic a_send(input logic [31:0] w);
        int n = 0;
        a_tx_data  = w;
        a_tx_valid = 1'b1;
        while (!a_tx_ready && n < 200) begin tick(1); n++; end
        chk("a_accept_timeout", 32'(n < 200), 32'd1);
        tick(1);
        a_tx_valid = 1'b0;
        a_tx_data  = 32'hxxxx_xxxx;
    endtask

    task automatic set_line(input int sel, input logic v, input int bc);
        if (sel == 0) a_drv = v; else c_drv = v;
        tick(bc);
    endtask

    // Drive a complete frame (start, nbits LSB first, given stop level) on A or C's link_in.
    task automatic drive_line(input int sel, input logic [31:0] w, input int nbits,
                              input int bc, input logic stop);
        set_line(sel, 1'b0, bc);
        for (int i = 0; i < nbits; i++) set_line(sel, w[i], bc);
        set_line(sel, stop, bc);
    endtask

    logic [31:0] t1_word = 32'hA5A5_0F01;
    logic [31:0] bw [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    int base_a;
    logic [7:0] c_cap;

    initial begin
        resetb = 1'b0;
        a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b0; a_loop = 1'b1; a_drv = 1'b1;
        b_tx_data = '0; b_tx_valid = 1'b0;
        c_tx_data = '0; c_tx_valid = 1'b0; c_rx_ready = 1'b0; c_drv = 1'b1;
        tick(2);

        // Reset state
        chk("rst_link_out", a_link_out, 1);
        chk("rst_tx_ready", a_tx_ready, 1);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_rx_data", a_rx_data, 0);
        chk("rst_frame_err", a_ferr, 0);
        chk("rst_overrun", a_ovr, 0);
        resetb = 1'b1;
        tick(2);

        // Test 1: serial waveform and loopback latency at BIT_CYCLES=1
        a_send(t1_word);
        chk("t1_start_bit", a_link_out, 0);
        chk("t1_tx_busy", a_tx_ready, 0);
        for (int i = 0; i < 32; i++) begin
            tick(1);
            chk($sformatf("t1_bit%0d", i), a_link_out, t1_word[i]);
        end
        tick(1);
        chk("t1_stop_bit", a_link_out, 1);
        tick(1);
        chk("t1_rx_valid_at35", a_rx_valid, 0);
        tick(1);
        chk("t1_rx_valid_at36", a_rx_valid, 1);
        chk("t1_rx_data", a_rx_data, t1_word);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
        chk("t1_rx_consumed", a_rx_valid, 0);

        // Test 3a: holding register full -> second word dropped, one overrun
        base_a = a_ovr_cnt;
        a_send(32'h1111_1111);
        a_send(32'h2222_2222);
        tick(40);
        chk("t3_held_valid", a_rx_valid, 1);
        chk("t3_held_data", a_rx_data, 32'h1111_1111);
        chk("t3_overrun_cnt", a_ovr_cnt - base_a, 1);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;

        // Test 3b: handshake in the completion cycle replaces the word, no overrun
        a_send(32'h1111_1111);
        tick(40);
        chk("t3b_first_valid", a_rx_valid, 1);
        base_a = a_ovr_cnt;
        a_send(32'h2222_2222);
        tick(34);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
        chk("t3b_valid", a_rx_valid, 1);
        chk("t3b_data", a_rx_data, 32'h2222_2222);
        tick(3);
        chk("t3b_no_overrun", a_ovr_cnt - base_a, 0);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;

        // Test 4: bad stop bit, line held low, then a good frame
        a_loop = 1'b0;
        a_drv  = 1'b1;
        tick(2);
        base_a = a_ferr_cnt;
        drive_line(0, 32'hDEAD_BEEF, 32, 1, 1'b0);
        tick(10);
        a_drv = 1'b1;
        tick(5);
        chk("t4_frame_err_cnt", a_ferr_cnt - base_a, 1);
        chk("t4_no_valid", a_rx_valid, 0);
        drive_line(0, 32'h1234_5678, 32, 1, 1'b1);
        tick(5);
        chk("t4_good_valid", a_rx_valid, 1);
        chk("t4_good_data", a_rx_data, 32'h1234_5678);
        chk("t4_frame_err_after", a_ferr_cnt - base_a, 1);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;

        // Test 5: asynchronous reset mid-DATA on both directions
        a_loop = 1'b1;
        base_a = a_ferr_cnt;
        a_send(32'h5555_AAAA);
        tick(9);
        chk("t5_pre_reset_bit8", a_link_out, 0);
        #2 resetb = 1'b0;
        #1 chk("t5_async_link_out", a_link_out, 1);
        tick(2);
        resetb = 1'b1;
        tick(1);
        chk("t5_tx_ready", a_tx_ready, 1);
        tick(40);
        chk("t5_no_spurious_valid", a_rx_valid, 0);
        chk("t5_no_frame_err", a_ferr_cnt - base_a, 0);
        a_send(32'hCAFE_F00D);
        tick(38);
        chk("t5_after_valid", a_rx_valid, 1);
        chk("t5_after_data", a_rx_data, 32'hCAFE_F00D);

        // Test 2: BIT_CYCLES=4, tx_valid held across three words
        b_tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            b_tx_data = bw[k];
            while (!b_tx_ready && n < 500) begin tick(1); n++; end
            chk("t2_accept_timeout", 32'(n < 500), 32'd1);
            tick(1);
        end
        b_tx_valid = 1'b0;
        tick(3 * 137 + 20);
        chk("t2_rx_count", b_rx_q.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2_word%0d", k), (k < b_rx_q.size()) ? b_rx_q[k] : 32'hxxxx_xxxx, bw[k]);
        chk("t2_acc_count", b_acc_q.size(), 3);
        if (b_acc_q.size() == 3) begin
            chk("t2_spacing_01", b_acc_q[1] - b_acc_q[0], 137);
            chk("t2_spacing_12", b_acc_q[2] - b_acc_q[1], 137);
        end
        chk("t2_no_errors", b_err_cnt, 0);

        // Test 6: WORD_W=8, BIT_CYCLES=3, TX 0x3C and RX 0xC3 concurrently
        c_tx_data  = 8'h3C;
        c_tx_valid = 1'b1;
        tick(1);
        c_tx_valid = 1'b0;
        fork
            drive_line(1, 32'h0000_00C3, 8, 3, 1'b1);
            begin
                chk("t6_tx_start", c_link_out, 0);
                tick(1);
                for (int i = 0; i < 8; i++) begin
                    tick(3);
                    c_cap[i] = c_link_out;
                end
                tick(3);
                chk("t6_tx_stop", c_link_out, 1);
                chk("t6_tx_data", c_cap, 8'h3C);
            end
        join
        tick(10);
        chk("t6_rx_valid", c_rx_valid, 1);
        chk("t6_rx_data", c_rx_data, 8'hC3);
        chk("t6_no_errors", c_err_cnt, 0);
        chk("t6_tx_idle", c_tx_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
